// File: rtl/message_scheduler_if.sv
// Handshake and schedule-word bundle between the message source, the
// message scheduler and the round compressor.
interface message_scheduler_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic              en;
  logic [WORD_W-1:0] w;
  logic              w_valid;
  logic [5:0]        round;
  logic              done;

  modport master (
    output in_word, in_valid, en,
    input  in_ready, w, w_valid, round, done
  );

  modport slave (
    input  in_word, in_valid, en,
    output in_ready, w, w_valid, round, done
  );
endinterface

// File: rtl/message_scheduler.sv
// SHA-256 message scheduler: loads 16 message words, then streams W0..W63
// from a 16-entry circular buffer in lock-step with the compressor rounds.
module message_scheduler #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  message_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [3:0]        cnt;
  logic [5:0]        round_q;
  logic [WORD_W-1:0] sched [16];

  logic [3:0]        slot;
  logic [3:0]        slot_m2;
  logic [3:0]        slot_m7;
  logic [3:0]        slot_m15;
  logic [WORD_W-1:0] w_calc;
  logic              accept;
  logic              advance;
  logic              last_round;

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // 4-bit slot arithmetic wraps mod 16, which is exactly the circular index.
  assign slot       = round_q[3:0];
  assign slot_m2    = slot - 4'd2;
  assign slot_m7    = slot - 4'd7;
  assign slot_m15   = slot + 4'd1;
  assign accept     = (state == S_LOAD) && bus.in_valid;
  assign advance    = (state == S_RUN) && bus.en;
  assign last_round = (round_q == 6'(ROUNDS - 1));

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path through it can infer a latch.
  always_comb begin
    w_calc = sched[slot];
    if (round_q >= 6'd16) begin
      w_calc = sigma1(sched[slot_m2]) + sched[slot_m7]
             + sigma0(sched[slot_m15]) + sched[slot];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD: if (accept && cnt == 4'd15) state_nx = S_RUN;
      S_RUN:  if (advance && last_round)  state_nx = S_DONE;
      S_DONE: state_nx = S_LOAD;
      default: state_nx = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_LOAD;
      cnt     <= '0;
      round_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd15) round_q <= '0;
      end
      if (advance) round_q <= last_round ? 6'd0 : round_q + 6'd1;
    end
  end

  // NOTE: the buffer has no reset; every slot is rewritten during LOAD before
  // it is read, and leaving it unreset lets it map onto LUTRAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      sched[cnt] <= bus.in_word;
    end else if (advance) begin
      sched[slot] <= w_calc;
    end
  end

  assign bus.in_ready = (state == S_LOAD);
  assign bus.w_valid  = (state == S_RUN);
  assign bus.done     = (state == S_DONE);
  assign bus.w        = w_calc;
  assign bus.round    = round_q;

endmodule

// File: tb/tb_message_scheduler.sv
// Directed self-checking bench for message_scheduler against a flat-array
// software model of the SHA-256 message schedule.
module tb_message_scheduler;

  logic clk;
  logic rst_n;

  message_scheduler_if #(.WORD_W(32)) bus ();

  message_scheduler #(.WORD_W(32), .ROUNDS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed;
  int total;
  logic [31:0] m     [16];
  logic [31:0] exp_w [64];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_model();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        exp_w[t] = m[t];
      end else begin
        exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                 + exp_w[t-7]
                 + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                 + exp_w[t-16];
      end
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    m[0]  = 32'h61626380;
    m[15] = 32'h00000018;
    build_model();
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    build_model();
  endtask

  // Advance one clock; on return we sit at the falling edge, outputs settled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // gap = idle (in_valid low, junk data) cycles before each offered word.
  task automatic load_block(input int gap);
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        bus.in_word  = $urandom;
        check($sformatf("gap_ready_%0d", i), 64'(bus.in_ready), 64'd1);
        check($sformatf("gap_wvalid_%0d", i), 64'(bus.w_valid), 64'd0);
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_word  = m[i];
      check($sformatf("load_ready_%0d", i), 64'(bus.in_ready), 64'd1);
      check($sformatf("load_wvalid_%0d", i), 64'(bus.w_valid), 64'd0);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  // rand_en: ~50% en duty; hold_valid: drive changing words during RUN;
  // stop_at: return (without done) when that many words have been consumed.
  task automatic run_block(input bit rand_en, input bit hold_valid, input bit is_abc,
                           input int stop_at);
    int consumed = 0;
    int cycles   = 0;
    while (consumed < 64 && cycles < 1000) begin
      if (consumed == stop_at) return;
      check($sformatf("run_wvalid_%0d", consumed), 64'(bus.w_valid), 64'd1);
      check($sformatf("run_ready_%0d", consumed), 64'(bus.in_ready), 64'd0);
      check($sformatf("run_done_%0d", consumed), 64'(bus.done), 64'd0);
      check($sformatf("round_%0d", consumed), 64'(bus.round), 64'(consumed));
      check($sformatf("w_%0d", consumed), 64'(bus.w), 64'(exp_w[consumed]));
      if (is_abc) begin
        if (consumed == 16) check("w16_abc", 64'(bus.w), 64'h61626380);
        if (consumed == 17) check("w17_abc", 64'(bus.w), 64'h000F0000);
        if (consumed == 18) check("w18_abc", 64'(bus.w), 64'h7DA86405);
      end
      bus.en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold_valid) begin
        bus.in_valid = 1'b1;
        bus.in_word  = $urandom;
      end
      step();
      if (bus.en) consumed++;
      cycles++;
    end
    if (consumed < 64) check("run_timeout", 64'(consumed), 64'd64);
    bus.in_valid = 1'b0;
    bus.en       = 1'b1;
    check("done_pulse", 64'(bus.done), 64'd1);
    check("done_wvalid", 64'(bus.w_valid), 64'd0);
    check("done_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("post_done", 64'(bus.done), 64'd0);
    check("post_done_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rst_n        = 1'b0;
    bus.in_word  = '0;
    bus.in_valid = 1'b0;
    bus.en       = 1'b1;
    @(negedge clk);
    do_reset();
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_wvalid", 64'(bus.w_valid), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_round", 64'(bus.round), 64'd0);

    // abc block, continuous valid and en
    set_abc();
    load_block(0);
    run_block(1'b0, 1'b0, 1'b1, -1);

    // abc block, random en gaps
    load_block(0);
    run_block(1'b1, 1'b0, 1'b1, -1);

    // valid only every third cycle during LOAD
    load_block(2);
    run_block(1'b0, 1'b0, 1'b1, -1);

    // in_valid held high with changing data during RUN
    load_block(0);
    run_block(1'b1, 1'b1, 1'b1, -1);

    // reset at round 30
    load_block(0);
    run_block(1'b0, 1'b0, 1'b1, 30);
    check("pre_rst_round", 64'(bus.round), 64'd30);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_wvalid", 64'(bus.w_valid), 64'd0);
    check("midrst_round", 64'(bus.round), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    step();
    check("midrst_done_next", 64'(bus.done), 64'd0);
    load_block(0);
    run_block(1'b0, 1'b0, 1'b1, -1);

    // two back-to-back random blocks
    set_random();
    load_block(0);
    run_block(1'b0, 1'b0, 1'b0, -1);
    set_random();
    load_block(0);
    run_block(1'b1, 1'b0, 1'b0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/message_scheduler.md
Name: message_scheduler

Overview:
- Upstream neighbour of the round compressor. Accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready handshake.
- Then emits the 64 SHA-256 schedule words W0..W63, one per enabled cycle, in lock-step with the compressor rounds.
- Uses a 16-entry circular buffer with the FIPS 180-4 recurrence: W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32.
- Sits inside the update wrapper, which also drives the compressor en and the k ROM from `round`.

Parameters:
- WORD_W, 32, schedule word width (fixed by algorithm; not to be overridden)
- ROUNDS, 64, schedule words emitted per block

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- in_word  in  32  message word M[i], big-endian word order
- in_valid  in  1  in_word valid
- in_ready  out  1  scheduler can accept a message word
- en  in  1  compressor consumes current w this cycle (advance)
- w  out  32  schedule word W[round]
- w_valid  out  1  w/round meaningful (RUN state)
- round  out  6  index t of current w
- done  out  1  one-cycle pulse after W63 consumed

Behaviour:
- Interface: one clock domain on clk. Reset is synchronous and active-low on rst_n, sampled only at the rising edge of clk.
- Reset (rst_n=0 at clk edge) forces:
  - state=LOAD, load counter=0, round=0
  - in_ready=1, w_valid=0, done=0
  - Buffer contents don't-care, not cleared.
  - Reset mid-LOAD or mid-RUN discards the partial block; no done pulse.
- State LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: buf[cnt] <= in_word, cnt++.
  - On the 16th accepted word: cnt <= 0, round <= 0, state <= RUN.
  - en is ignored in LOAD.
- State RUN:
  - in_ready=0; in_valid ignored, words not consumed. w_valid=1.
  - w is combinational from the buffer and round:
    - round<16: w = buf[round].
    - round>=16: w = sigma1(buf[(round-2)&15]) + buf[(round-7)&15] + sigma0(buf[(round+1)&15]) + buf[round&15], 32-bit wrap, carries discarded.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - On en=1: buf[round&15] <= w, round <= round+1. For round<16 the write is a no-op rewrite.
  - On en=0: hold everything; w stable. Gaps of any length are allowed.
  - On en=1 at round=63: state <= DONE, round <= 0.
- State DONE:
  - Lasts exactly one cycle: done=1, w_valid=0, in_ready=0.
  - Next state is LOAD.
- Latency:
  - W0 is valid on the cycle after the 16th word handshake.
  - Block throughput = 16 load + 64 run + 1 done cycles minimum.
- Simultaneous events: rst_n=0 has priority over everything. en and in_valid never interact, because states are exclusive.
- Storage: single 16x32 register file or LUTRAM. One write port; four read ports in RUN (slot ports may share in LOAD).

Test Plan:
1. Reset, then load "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018) with in_valid held high, en held high:
   - Expected: in_ready drops after 16 words.
   - Rounds 0..15 echo M.
   - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405.
   - All 64 words match the software model.
   - done pulses exactly one cycle after the round=63 consume.
2. Same block with en toggled pseudo-randomly (~50% duty):
   - Expected: identical W sequence.
   - w and round are stable across every en=0 cycle.
   - Exactly 64 en=1 cycles in RUN before done.
3. in_valid gaps during LOAD (valid every third cycle) -> only handshaken words stored; RUN entered after the 16th accept only.
4. in_valid held high during RUN with a changing in_word -> in_ready=0 throughout; W sequence unaffected.
5. rst_n=0 for one cycle at round=30 -> next cycle state LOAD, in_ready=1, w_valid=0, round=0, no done. A fresh "abc" load then reproduces test 1 exactly.
6. Two back-to-back blocks (random vs. software model), where block 2's first word is offered in the cycle after done -> both schedules correct; no stale data from block 1 in block 2's W16..W63.
